// File: rtl/tmds_pkg.sv
// Shared TMDS encoder definitions: default character width and a reference popcount.
package tmds_pkg;

  localparam int unsigned TMDS_WIDTH = 8;
  localparam int unsigned TMDS_RES_W = $clog2(TMDS_WIDTH + 1);

  // Number of set bits in a default-width character.
  function automatic logic [TMDS_RES_W-1:0] popcount(input logic [TMDS_WIDTH-1:0] word);
    logic [TMDS_RES_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < TMDS_WIDTH; i++) begin
      acc = acc + TMDS_RES_W'(word[i]);
    end
    return acc;
  endfunction

endpackage

// File: rtl/num_of_ones_cnt_if.sv
// Word-in / count-out bundle between an encoder channel and its ones counter.
interface num_of_ones_cnt_if
  import tmds_pkg::*;
#(
  parameter int unsigned WIDTH = TMDS_WIDTH,
  parameter int unsigned RES_W = $clog2(WIDTH + 1)
);

  logic [WIDTH-1:0]   onesFrom;
  logic               inValid;
  logic [RES_W-1:0]   result;
  logic [RES_W-1:0]   resultQ;
  logic               outValid;
  logic               overHalfQ;
  logic               halfQ;
  logic signed [RES_W:0] disparityQ;

  modport master (
    output onesFrom, inValid,
    input  result, resultQ, outValid, overHalfQ, halfQ, disparityQ
  );

  modport slave (
    input  onesFrom, inValid,
    output result, resultQ, outValid, overHalfQ, halfQ, disparityQ
  );

endinterface

// File: rtl/num_of_ones_cnt.sv
// Ones counter for TMDS encoding: combinational count plus a registered count
// with the over-half / exactly-half flags and signed disparity 2*count-WIDTH.
module num_of_ones_cnt
  import tmds_pkg::*;
#(
  parameter int unsigned WIDTH = TMDS_WIDTH,
  parameter int unsigned RES_W = $clog2(WIDTH + 1)
) (
  input  logic                 pixelClk,
  input  logic                 rstN,
  num_of_ones_cnt_if.slave     cnt_if
);

  localparam int unsigned DISP_W = RES_W + 1;
  localparam int unsigned HALF   = WIDTH / 2;

  logic [RES_W-1:0]  cnt_c;
  logic [RES_W-1:0]  result_d, result_q;
  logic              over_d, over_q;
  logic              half_d, half_q;
  logic [DISP_W-1:0] disp_d, disp_q;
  logic              valid_d, valid_q;

  // Default width reuses the shared reference function; other widths use a plain loop.
  if (WIDTH == TMDS_WIDTH && RES_W == TMDS_RES_W) begin : g_pkg_cnt
    assign cnt_c = popcount(cnt_if.onesFrom);
  end else begin : g_loop_cnt
    always_comb begin
      cnt_c = '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_c = cnt_c + RES_W'(cnt_if.onesFrom[i]);
      end
    end
  end

  // Capture a new sample only when qualified; otherwise hold.
  always_comb begin
    result_d = result_q;
    over_d   = over_q;
    half_d   = half_q;
    disp_d   = disp_q;
    valid_d  = cnt_if.inValid;
    if (cnt_if.inValid) begin
      result_d = cnt_c;
      over_d   = (cnt_c > RES_W'(HALF));
      half_d   = (cnt_c == RES_W'(HALF));
      disp_d   = ({1'b0, cnt_c} << 1) - DISP_W'(WIDTH);
    end
  end

  always_ff @(posedge pixelClk or negedge rstN) begin
    if (!rstN) begin
      result_q <= '0;
      over_q   <= 1'b0;
      half_q   <= 1'b0;
      disp_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      over_q   <= over_d;
      half_q   <= half_d;
      disp_q   <= disp_d;
      valid_q  <= valid_d;
    end
  end

  assign cnt_if.result     = cnt_c;
  assign cnt_if.resultQ    = result_q;
  assign cnt_if.overHalfQ  = over_q;
  assign cnt_if.halfQ      = half_q;
  assign cnt_if.disparityQ = disp_q;
  assign cnt_if.outValid   = valid_q;

endmodule

// File: tb/tb_num_of_ones_cnt.sv
// Bench for num_of_ones_cnt: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed values.
module tb_num_of_ones_cnt;

  localparam int W = 8;

  logic pixelClk;
  logic rstN;
  int   n_vec;
  int   n_err;
  bit   run;

  num_of_ones_cnt_if bus ();

  num_of_ones_cnt dut (
    .pixelClk (pixelClk),
    .rstN     (rstN),
    .cnt_if   (bus)
  );

  initial begin
    pixelClk = 1'b0;
    forever #5 pixelClk = ~pixelClk;
  end

  // Reference: what the registered outputs must hold, from the stated rules.
  int m_cnt, m_disp;
  bit m_valid, m_over, m_half;

  always @(posedge pixelClk or negedge rstN) begin
    if (!rstN) begin
      m_valid <= 1'b0; m_cnt <= 0; m_disp <= 0; m_over <= 1'b0; m_half <= 1'b0;
    end else begin
      m_valid <= bus.inValid;
      if (bus.inValid) begin
        m_cnt  <= $countones(bus.onesFrom);
        m_disp <= 2 * $countones(bus.onesFrom) - W;
        m_over <= ($countones(bus.onesFrom) > W / 2);
        m_half <= ($countones(bus.onesFrom) == W / 2);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process on the falling edge, away from the capture edge.
  always @(negedge pixelClk) begin
    if (run && rstN === 1'b1) begin
      chk("result_comb", int'(bus.result), $countones(bus.onesFrom));
      chk("outValid",    int'(bus.outValid), int'(m_valid));
      chk("resultQ",     int'(bus.resultQ), m_cnt);
      chk("overHalfQ",   int'(bus.overHalfQ), int'(m_over));
      chk("halfQ",       int'(bus.halfQ), int'(m_half));
      chk("disparityQ",  int'(bus.disparityQ), m_disp);
      if (bus.outValid) begin
        chk("flag_excl",  int'(bus.overHalfQ & bus.halfQ), 0);
        chk("disp_sign",  int'(bus.disparityQ > 0), int'(bus.overHalfQ));
        chk("disp_zero",  int'(bus.disparityQ == 0), int'(bus.halfQ));
      end
    end
  end

  // Inputs change 2 time units after the rising edge; outputs reflect the previous step.
  task automatic step(input logic [7:0] d, input logic v);
    @(posedge pixelClk);
    #2;
    bus.onesFrom = d;
    bus.inValid  = v;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resultQ"},  int'(bus.resultQ), 0);
    chk({tag, "_outValid"}, int'(bus.outValid), 0);
    chk({tag, "_overHalf"}, int'(bus.overHalfQ), 0);
    chk({tag, "_half"},     int'(bus.halfQ), 0);
    chk({tag, "_disp"},     int'(bus.disparityQ), 0);
  endtask

  task automatic reset_pulse(input string tag);
    #3;
    rstN = 1'b0;
    #1;
    chk_all_zero(tag);
    #1;
    rstN = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] first_post;
    n_vec = 0; n_err = 0; run = 1'b0;
    rstN = 1'b0;
    bus.onesFrom = 8'h00;
    bus.inValid  = 1'b0;
    #1;
    chk_all_zero("por");
    #11;
    rstN = 1'b1;
    run  = 1'b1;

    // 0xF7: seven ones
    step(8'hF7, 1'b1);
    step(8'hF7, 1'b0);
    chk("f7_resultQ", int'(bus.resultQ), 7);
    chk("f7_over",    int'(bus.overHalfQ), 1);
    chk("f7_half",    int'(bus.halfQ), 0);
    chk("f7_disp",    int'(bus.disparityQ), 6);
    chk("f7_valid",   int'(bus.outValid), 1);

    // back-to-back 0x11 then 0x3C
    step(8'h11, 1'b1);
    step(8'h3C, 1'b1);
    chk("11_resultQ", int'(bus.resultQ), 2);
    chk("11_disp",    int'(bus.disparityQ), -4);
    chk("11_half",    int'(bus.halfQ), 0);
    step(8'h00, 1'b0);
    chk("3c_resultQ", int'(bus.resultQ), 4);
    chk("3c_disp",    int'(bus.disparityQ), 0);
    chk("3c_half",    int'(bus.halfQ), 1);

    // hold while unqualified; combinational output keeps tracking
    step(8'h01, 1'b1);
    step(8'hFF, 1'b0);
    chk("hold_comb_ff", int'(bus.result), 8);
    step(8'h00, 1'b0);
    chk("hold_resultQ", int'(bus.resultQ), 1);
    chk("hold_valid",   int'(bus.outValid), 0);
    chk("hold_comb_00", int'(bus.result), 0);

    // exhaustive sweep, qualified every cycle
    for (int i = 0; i < 256; i++) begin
      d = 8'(i);
      step(d, 1'b1);
      case (d)
        8'h00: chk("sweep_00", int'(bus.result), 0);
        8'hFF: chk("sweep_ff", int'(bus.result), 8);
        8'hA5: chk("sweep_a5", int'(bus.result), 4);
        8'h80: chk("sweep_80", int'(bus.result), 1);
        default: ;
      endcase
    end
    step(8'h00, 1'b1);
    chk("ff_disp", int'(bus.disparityQ), 8);
    chk("ff_over", int'(bus.overHalfQ), 1);
    step(8'h0F, 1'b1);
    chk("00_disp", int'(bus.disparityQ), -8);
    chk("00_resultQ", int'(bus.resultQ), 0);
    step(8'h3F, 1'b1);
    chk("0f_half", int'(bus.halfQ), 1);
    chk("0f_disp", int'(bus.disparityQ), 0);

    // asynchronous reset pulse mid-stream, between edges
    step(8'hE0, 1'b1);
    reset_pulse("rst_mid");
    first_post = 8'hE0;
    step(8'h5A, 1'b1);
    chk("post_rst_resultQ", int'(bus.resultQ), $countones(first_post));
    chk("post_rst_valid",   int'(bus.outValid), 1);
    step(8'h00, 1'b0);
    chk("post_rst_disp", int'(bus.disparityQ), 0);

    // randomised traffic with one more reset pulse
    for (int i = 0; i < 10000; i++) begin
      step(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if (i == 5000) reset_pulse("rst_rand");
    end

    step(8'h00, 1'b0);
    @(negedge pixelClk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
